// File: rtl/i2s_recorder_mc.sv
// i2s_recorder_mc
// ---------------------------------------------------------------------------
// I2S capture engine running on the bit clock. It deserialises DATA_W-bit
// words from the ADC, records left-only, right-only or interleaved stereo,
// and emits a one-cycle write strobe with address/data toward the SRAM side.
//
// Parameters
//   DATA_W   sample width (1 .. bclk-per-LRC-half - 1)
//   ADDR_W   address width
//   MAX_ADDR last writable address (odd in stereo mode)
//   CH_MODE  0 = left only, 1 = right only, 2 = stereo (L even, R odd)
//
// Ports
//   i_clk        bit clock, all logic on rising edge
//   i_rst        synchronous active-high reset
//   i_lrc        LR clock (0 = left slot, 1 = right slot)
//   i_data       serial data, MSB first, one bit after the LRC edge
//   i_start      start / resume request (level)
//   i_pause      pause request (level)
//   i_stop       stop request (level)
//   o_wr_en      one-cycle write strobe
//   o_address    write address, valid with o_wr_en, held afterwards
//   o_data       captured sample, valid with o_wr_en, held afterwards
//   o_channel    channel of o_data (0 = L, 1 = R)
//   o_recording  high while armed or recording
//   o_full       high once the last address has been written
// ---------------------------------------------------------------------------
module i2s_recorder_mc #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 20,
   parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}},
   parameter int                CH_MODE  = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_lrc,
   input  logic              i_data,
   input  logic              i_start,
   input  logic              i_pause,
   input  logic              i_stop,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_address,
   output logic [DATA_W-1:0] o_data,
   output logic              o_channel,
   output logic              o_recording,
   output logic              o_full
);

   localparam int CNT_W = $clog2(DATA_W + 2);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_REC,
      S_PAUSED,
      S_FULL
   } state_t;

   state_t            state_reg;
   logic              lrc_q_reg;
   logic              pause_pending_reg;
   logic              cap_active_reg;
   logic [CNT_W-1:0]  bit_cnt_reg;
   logic              slot_ch_reg;
   logic [DATA_W-1:0] sr_reg;
   logic [ADDR_W-1:0] addr_cnt_reg;
   logic              wr_en_reg;
   logic [ADDR_W-1:0] address_reg;
   logic [DATA_W-1:0] data_reg;
   logic              channel_reg;
   logic              full_reg;

   logic boundary;
   logic lrc_rise;
   logic lrc_fall;
   logic qual;

   assign boundary = (i_lrc != lrc_q_reg);
   assign lrc_rise = i_lrc & ~lrc_q_reg;
   assign lrc_fall = ~i_lrc & lrc_q_reg;
   // The boundary that opens a recording / frame: rising for right-only,
   // falling (start of the left slot) otherwise.
   assign qual     = (CH_MODE == 1) ? lrc_rise : lrc_fall;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg         <= S_IDLE;
         lrc_q_reg         <= i_lrc;
         pause_pending_reg <= 1'b0;
         cap_active_reg    <= 1'b0;
         bit_cnt_reg       <= '0;
         slot_ch_reg       <= 1'b0;
         sr_reg            <= '0;
         addr_cnt_reg      <= '0;
         wr_en_reg         <= 1'b0;
         address_reg       <= '0;
         data_reg          <= '0;
         channel_reg       <= 1'b0;
         full_reg          <= 1'b0;
      end else begin
         lrc_q_reg <= i_lrc;
         wr_en_reg <= 1'b0;

         if (i_stop) begin
            // Abandon any partial word; committed outputs are held.
            state_reg         <= S_IDLE;
            cap_active_reg    <= 1'b0;
            pause_pending_reg <= 1'b0;
            full_reg          <= 1'b0;
         end else begin
            // Word in progress: bits E1..E_DATA_W shift in, commit at the
            // following edge. Runs in any state so a pause still lets the
            // current word finish.
            if (cap_active_reg) begin
               if (bit_cnt_reg <= LAST_BIT) begin
                  sr_reg      <= (sr_reg << 1) | DATA_W'(i_data);
                  bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
               end else begin
                  wr_en_reg      <= 1'b1;
                  data_reg       <= sr_reg;
                  address_reg    <= addr_cnt_reg;
                  channel_reg    <= slot_ch_reg;
                  cap_active_reg <= 1'b0;
               end
            end

            // Edge after a commit: advance the counter unless that was the
            // last address (FULL handling below).
            if (wr_en_reg && (address_reg != MAX_ADDR)) begin
               addr_cnt_reg <= addr_cnt_reg + ADDR_W'(1);
            end

            case (state_reg)
               S_IDLE: begin
                  if (i_start && !i_pause) begin
                     state_reg    <= S_ARMED;
                     addr_cnt_reg <= '0;
                  end
               end
               S_ARMED: begin
                  if (i_pause) begin
                     state_reg <= S_PAUSED;
                  end else if (boundary && qual) begin
                     state_reg      <= S_REC;
                     cap_active_reg <= 1'b1;
                     bit_cnt_reg    <= CNT_W'(1);
                     slot_ch_reg    <= i_lrc;
                  end
               end
               S_REC: begin
                  if (i_pause) begin
                     pause_pending_reg <= 1'b1;
                  end
                  if (boundary) begin
                     if (pause_pending_reg && qual) begin
                        // Land on a frame boundary; this slot is skipped.
                        state_reg         <= S_PAUSED;
                        pause_pending_reg <= 1'b0;
                     end else if ((CH_MODE == 2) || qual) begin
                        cap_active_reg <= 1'b1;
                        bit_cnt_reg    <= CNT_W'(1);
                        slot_ch_reg    <= i_lrc;
                     end
                  end
               end
               S_PAUSED: begin
                  if (i_start && !i_pause) begin
                     state_reg <= S_ARMED;
                  end
               end
               S_FULL: begin
               end
               default: state_reg <= S_IDLE;
            endcase

            // Last address just written: terminal until stop.
            if (wr_en_reg && (address_reg == MAX_ADDR)) begin
               state_reg         <= S_FULL;
               full_reg          <= 1'b1;
               cap_active_reg    <= 1'b0;
               pause_pending_reg <= 1'b0;
            end
         end
      end
   end

   assign o_wr_en     = wr_en_reg;
   assign o_address   = address_reg;
   assign o_data      = data_reg;
   assign o_channel   = channel_reg;
   assign o_recording = (state_reg == S_ARMED) || (state_reg == S_REC);
   assign o_full      = full_reg;

endmodule

// File: tb/tb_i2s_recorder_mc.sv
// Directed bench for i2s_recorder_mc. Three instances share one stimulus:
// default stereo/16-bit, right-only/24-bit, and stereo with MAX_ADDR=3.
module tb_i2s_recorder_mc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1, lrc = 1'b1, din = 1'b0;
   logic start = 1'b0, pause = 1'b0, stop = 1'b0;

   logic        a_wr, a_ch, a_rec, a_full;
   logic [19:0] a_addr;
   logic [15:0] a_data;
   logic        r_wr, r_ch, r_rec, r_full;
   logic [19:0] r_addr;
   logic [23:0] r_data;
   logic        f_wr, f_ch, f_rec, f_full;
   logic [19:0] f_addr;
   logic [15:0] f_data;

   i2s_recorder_mc u_a (
      .i_clk(clk), .i_rst(rst), .i_lrc(lrc), .i_data(din),
      .i_start(start), .i_pause(pause), .i_stop(stop),
      .o_wr_en(a_wr), .o_address(a_addr), .o_data(a_data),
      .o_channel(a_ch), .o_recording(a_rec), .o_full(a_full));

   i2s_recorder_mc #(.DATA_W(24), .CH_MODE(1)) u_r (
      .i_clk(clk), .i_rst(rst), .i_lrc(lrc), .i_data(din),
      .i_start(start), .i_pause(pause), .i_stop(stop),
      .o_wr_en(r_wr), .o_address(r_addr), .o_data(r_data),
      .o_channel(r_ch), .o_recording(r_rec), .o_full(r_full));

   i2s_recorder_mc #(.MAX_ADDR(20'd3)) u_f (
      .i_clk(clk), .i_rst(rst), .i_lrc(lrc), .i_data(din),
      .i_start(start), .i_pause(pause), .i_stop(stop),
      .o_wr_en(f_wr), .o_address(f_addr), .o_data(f_data),
      .o_channel(f_ch), .o_recording(f_rec), .o_full(f_full));

   typedef struct {
      int addr;
      int data;
      int ch;
      int lat;
      int cyc;
   } rec_t;

   rec_t q_a[$];
   rec_t q_r[$];
   rec_t q_f[$];

   int   total = 0;
   int   bad   = 0;
   int   since_b = 0;
   int   cyc = 0;
   int   full_rise_cyc = -100;
   logic lrc_prev = 1'b1;
   logic f_full_prev = 1'b0;

   // Edges since the last LRC change as seen by the DUT (E0 -> 0).
   always @(posedge clk) begin
      lrc_prev <= lrc;
      if (lrc != lrc_prev) since_b <= 0;
      else                 since_b <= since_b + 1;
   end

   // Strobe log for every instance, one line per transaction.
   always @(negedge clk) begin
      rec_t r;
      cyc <= cyc + 1;
      if (a_wr) begin
         r = '{int'(a_addr), int'(a_data), int'(a_ch), since_b, cyc};
         q_a.push_back(r);
         $display("wr a: addr=%0d data=%h ch=%0d lat=%0d", a_addr, a_data, a_ch, since_b);
      end
      if (r_wr) begin
         r = '{int'(r_addr), int'(r_data), int'(r_ch), since_b, cyc};
         q_r.push_back(r);
         $display("wr r: addr=%0d data=%h ch=%0d lat=%0d", r_addr, r_data, r_ch, since_b);
      end
      if (f_wr) begin
         r = '{int'(f_addr), int'(f_data), int'(f_ch), since_b, cyc};
         q_f.push_back(r);
         $display("wr f: addr=%0d data=%h ch=%0d lat=%0d", f_addr, f_data, f_ch, since_b);
      end
      if (f_full && !f_full_prev) full_rise_cyc <= cyc;
      f_full_prev <= f_full;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic check_rec(input string tag, input rec_t r, input int addr,
                            input int data, input int ch, input int lat);
      check({tag, "_addr"}, r.addr, addr);
      check({tag, "_data"}, r.data, data);
      check({tag, "_ch"},   r.ch,   ch);
      check({tag, "_lat"},  r.lat,  lat);
   endtask

   // One 32-bclk LRC half. MSB goes out one bclk after the LRC change.
   // act = {rst, stop, pause, start}, pulsed for the edge E_act_k.
   task automatic slot(input logic ch, input logic [31:0] word, input int w,
                       input int act_k, input logic [3:0] act);
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         lrc = ch;
         din = (k >= 1 && k <= w) ? word[w-k] : 1'b0;
         {rst, stop, pause, start} = (k == act_k) ? act : 4'b0000;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      q_a.delete();
      q_r.delete();
      q_f.delete();
   endtask

   localparam logic [3:0] A_START = 4'b0001;
   localparam logic [3:0] A_PAUSE = 4'b0010;
   localparam logic [3:0] A_STOP  = 4'b0100;
   localparam logic [3:0] A_ALL   = 4'b0111;
   localparam logic [3:0] A_RST   = 4'b1000;

   int t1d[4] = '{32'hf0e1, 32'hd2c3, 32'hb4a5, 32'h9687};
   int t2d[6] = '{32'h1a2b, 32'h3c4d, 32'h5e6f, 32'h7081, 32'h92a3, 32'hb4c5};

   initial begin
      // ---- reset state ----
      do_reset();
      check("rst_wr",   a_wr,   0);
      check("rst_addr", a_addr, 0);
      check("rst_data", a_data, 0);
      check("rst_ch",   a_ch,   0);
      check("rst_rec",  a_rec,  0);
      check("rst_full", a_full, 0);

      // ---- 1: stereo, four words ----
      slot(1, 0, 16, 5, A_START);
      check("t1_armed", a_rec, 1);
      slot(0, t1d[0], 16, -1, 0);
      slot(1, t1d[1], 16, -1, 0);
      slot(0, t1d[2], 16, -1, 0);
      slot(1, t1d[3], 16, -1, 0);
      check("t1_n", q_a.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < q_a.size()) check_rec($sformatf("t1_%0d", i), q_a[i], i, t1d[i], i % 2, 17);

      // ---- 2: pause during L word at address 2, resume two frames later ----
      do_reset();
      slot(1, 0, 16, 5, A_START);
      slot(0, t2d[0], 16, -1, 0);
      slot(1, t2d[1], 16, -1, 0);
      slot(0, t2d[2], 16, 8, A_PAUSE);
      slot(1, t2d[3], 16, -1, 0);
      slot(0, 32'hdead, 16, -1, 0);
      check("t2_paused_rec", a_rec, 0);
      slot(1, 32'hdead, 16, -1, 0);
      slot(0, 32'hdead, 16, -1, 0);
      slot(1, 32'hdead, 16, 5, A_START);
      slot(0, t2d[4], 16, -1, 0);
      slot(1, t2d[5], 16, -1, 0);
      check("t2_n", q_a.size(), 6);
      for (int i = 0; i < 6; i++)
         if (i < q_a.size()) check_rec($sformatf("t2_%0d", i), q_a[i], i, t2d[i], i % 2, 17);

      // ---- 3: stop at E8, then restart from address 0 ----
      do_reset();
      slot(1, 0, 16, 5, A_START);
      slot(0, 32'h0a0b, 16, -1, 0);
      slot(1, 32'h0c0d, 16, -1, 0);
      slot(0, 32'h0e0f, 16, 8, A_STOP);
      check("t3_n_stop", q_a.size(), 2);
      check("t3_addr_hold", a_addr, 1);
      check("t3_rec", a_rec, 0);
      slot(1, 0, 16, 5, A_START);
      slot(0, 32'h1357, 16, -1, 0);
      slot(1, 32'h2468, 16, -1, 0);
      check("t3_n", q_a.size(), 4);
      if (q_a.size() >= 4) begin
         check_rec("t3_2", q_a[2], 0, 32'h1357, 0, 17);
         check_rec("t3_3", q_a[3], 1, 32'h2468, 1, 17);
      end

      // ---- 4: right only, 24-bit ----
      do_reset();
      slot(0, 0, 24, 5, A_START);
      slot(1, 32'h123456, 24, -1, 0);
      slot(0, 32'h555555, 24, -1, 0);
      slot(1, 32'habcdef, 24, -1, 0);
      slot(0, 32'h555555, 24, -1, 0);
      check("t4_n", q_r.size(), 2);
      if (q_r.size() >= 2) begin
         check_rec("t4_0", q_r[0], 0, 32'h123456, 1, 25);
         check_rec("t4_1", q_r[1], 1, 32'habcdef, 1, 25);
      end

      // ---- 5: MAX_ADDR=3, three frames ----
      do_reset();
      slot(1, 0, 16, 5, A_START);
      for (int i = 0; i < 6; i++) slot(i[0], 32'h4000 + i, 16, -1, 0);
      check("t5_n", q_f.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < q_f.size()) check_rec($sformatf("t5_%0d", i), q_f[i], i, 32'h4000 + i, i % 2, 17);
      if (q_f.size() >= 4) check("t5_full_next", full_rise_cyc - q_f[3].cyc, 1);
      slot(0, 32'h7777, 16, 5, A_START);
      slot(1, 32'h7777, 16, -1, 0);
      check("t5_full_hold", f_full, 1);
      check("t5_rec", f_rec, 0);
      check("t5_n_after_start", q_f.size(), 4);
      slot(0, 0, 16, 5, A_STOP);
      check("t5_full_clr", f_full, 0);

      // ---- 6: start+pause+stop together in REC ----
      do_reset();
      slot(1, 0, 16, 5, A_START);
      slot(0, 32'hc001, 16, -1, 0);
      slot(1, 32'hc002, 16, 5, A_ALL);
      check("t6_rec", a_rec, 0);
      slot(0, 32'hc003, 16, -1, 0);
      check("t6_n", q_a.size(), 1);
      check("t6_addr", a_addr, 0);

      // ---- 6b: reset at E5 of a word ----
      do_reset();
      slot(1, 0, 16, 5, A_START);
      slot(0, 32'hbeef, 16, -1, 0);
      check("t6b_data_before", a_data, 32'hbeef);
      slot(1, 32'hcafe, 16, 5, A_RST);
      check("t6b_n", q_a.size(), 1);
      check("t6b_wr",   a_wr,   0);
      check("t6b_addr", a_addr, 0);
      check("t6b_data", a_data, 0);
      check("t6b_ch",   a_ch,   0);
      check("t6b_rec",  a_rec,  0);
      check("t6b_full", a_full, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2s_recorder_mc.md
# i2s_recorder_mc

Parametrised, multi-mode I2S capture engine: deserialises I2S audio on the bit clock, records left-only, right-only or interleaved stereo words, and emits a one-cycle write strobe with address and data toward the SRAM controller. Successor to the fixed 16-bit single-channel recorder. Adds:
- configurable sample width and address range;
- channel selection;
- pause that lands on a frame boundary;
- a full/overflow stop.

## Interface
- DATA_W, 16, sample width in bits. Must satisfy 1 ≤ DATA_W ≤ (bclk cycles per LRC half) − 1.
- ADDR_W, 20, address width.
- MAX_ADDR, 2**ADDR_W−1, last writable address. Must be odd when CH_MODE=2.
- CH_MODE, 2, channel mode: 0 = left only, 1 = right only, 2 = stereo interleaved (L at even, R at odd address).

Ports:
- i_clk  in  1  I2S bit clock (BCLK); all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_lrc  in  1  LR clock; 0 = left slot, 1 = right slot
- i_data  in  1  serial ADC data, MSB first
- i_start  in  1  start/resume request, level-sampled
- i_pause  in  1  pause request, level-sampled
- i_stop  in  1  stop request, level-sampled
- o_wr_en  out  1  one-cycle write strobe
- o_address  out  ADDR_W  write address, valid with o_wr_en
- o_data  out  DATA_W  captured sample, valid with o_wr_en
- o_channel  out  1  channel of o_data (0 = L, 1 = R)
- o_recording  out  1  high in ARMED or REC
- o_full  out  1  high in FULL

## Operation
States and transitions:
- IDLE
  - i_start → ARMED, with the address counter cleared to 0.
- ARMED
  - Waits for a qualifying boundary, then → REC.
  - Qualifying boundary: LRC falling edge for CH_MODE 0 or 2; LRC rising edge for CH_MODE 1.
- REC
  - Captures words: every boundary in stereo; only qualifying boundaries otherwise.
- PAUSED
  - i_start → ARMED with the address kept.
- FULL
  - Only i_stop exits (→ IDLE). i_start is ignored.

Boundary detection:
- Register lrc_q each cycle.
- A boundary is the edge where i_lrc ≠ lrc_q.

Capture:
- At boundary edge E0, the slot channel is i_lrc.
- E0 is the I2S delay bit and is not captured.
- i_data is shifted in at E1..E_DATA_W, MSB first.
- Remaining slot bits are ignored.

Commit, at E_(DATA_W+1):
- o_data takes the shift register value.
- o_address takes the counter value.
- o_channel takes the slot channel.
- o_wr_en goes to 1.

After commit, at the next edge:
- o_wr_en returns to 0.
- The counter increments by 1.
- If the committed address was MAX_ADDR: go to FULL and set o_full instead of incrementing.

Pause:
- In REC, i_pause sets pause_pending.
- The word in progress is completed and committed.
- At the next qualifying boundary: → PAUSED, and that slot is not captured.
- In stereo, pause therefore always lands after an R word, so L/R pairs stay intact.
- i_pause in ARMED → PAUSED immediately.

Stop:
- i_stop in any state → IDLE at the next edge.
- The partial word is discarded and no strobe is issued.
- o_address holds the last committed address.

Priority when requests coincide: i_stop > i_pause > i_start. A boundary on the same edge as i_start in IDLE/PAUSED is not used; capture begins at the following qualifying boundary.

## Timing
- Reset values (i_rst high at an edge):
  - all outputs 0;
  - state IDLE, counter 0, lrc_q ← i_lrc;
  - pause_pending 0.
- Latency: o_wr_en is high exactly DATA_W+1 edges after E0, for one cycle. For DATA_W=16 that is edge E17.
- Stereo with 32-bclk halves: exactly one strobe per slot, addresses strictly consecutive.
- Mid-word reset or stop: no strobe. The next recording starts at address 0 on the next qualifying boundary after start.
- Requests are level-sampled. Holding i_start for several cycles is equivalent to one pulse. Holding i_pause blocks resumption.
- Resume after pause: next address = last committed + 1.
- Word-pair integrity in stereo is preserved across pause/resume: resume waits for an LRC falling edge.
- Address counter never wraps. FULL is the only terminal condition.

## Test plan
1. Stereo, 32-bclk halves, DATA_W=16; serialise L=16'hf0e1, R=16'hd2c3, then L=16'hb4a5, R=16'h9687 after a start pulse.
   - Required: strobes at addresses 0,1,2,3 with data f0e1, d2c3, b4a5, 9687 and o_channel 0,1,0,1.
   - Each strobe 17 edges after its boundary.
2. Pause during word at address 2 (L), resume 2 frames later.
   - Required: words 2 (L) and 3 (R) still written.
   - No strobes while paused.
   - Next write is address 4, o_channel=0.
3. Stop asserted at E8 of a word, then start.
   - Required: no strobe for the partial word; o_address holds the last value.
   - After restart, first strobe at address 0.
4. CH_MODE=1, DATA_W=24, 32-bclk halves, R words 24'h123456, 24'habcdef.
   - Required: only right-slot strobes, at addresses 0,1, data as sent, each at E25.
5. MAX_ADDR=3, stereo, 3 full frames.
   - Required: strobes at addresses 0..3 only; o_full=1 the cycle after the address-3 strobe.
   - i_start ignored while full; i_stop clears o_full.
6. i_start, i_pause and i_stop all high on one edge during REC.
   - Required: → IDLE.
   - Separately: i_rst at E5 of a word → all outputs 0 next cycle, no strobe.
